pipe_if_stage: RTL and testbench
================================

# pipe_if_stage

Instruction-fetch stage of the static 5-stage MIPS pipeline. Holds the program counter, computes PC+4 through an `adder_32` instance, and selects the next PC from sequential, branch, jump and exception redirects. Presents the fetch address to the combinational instruction memory and latches the returned word into the IF/ID pipeline register consumed by the decode stage. Honours stall and flush requests from the hazard unit.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset.
- `NOP_WORD`, 32'h0000_0000, instruction word inserted into IF/ID for a bubble.

- `clk`  in  1  pipeline clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `branch_taken`  in  1  ID-stage branch resolved taken.
- `branch_target`  in  32  branch target from the ID-stage adder.
- `jump`  in  1  ID-stage j/jal/jr/jalr.
- `jump_target`  in  32  jump destination.
- `exc_redirect`  in  1  exception entry or eret from the CP0 unit.
- `exc_target`  in  32  exception vector or EPC.
- `imem_addr`  out  32  fetch address (equals current PC).
- `imem_rdata`  in  32  instruction word, combinational from `imem_addr`.
- `if_id_pc`  out  32  PC of the latched instruction.
- `if_id_pc4`  out  32  PC+4 of the latched instruction.
- `if_id_instr`  out  32  latched instruction word.
- `if_id_valid`  out  1  latched slot holds a real instruction.
- `fetch_count`  out  32  number of valid instructions latched into IF/ID.

## Operation
- FSM with two states:
  - `S_BOOT`: entered on reset, lasts exactly one cycle after reset deassertion; PC holds `RESET_PC`, IF/ID stays a bubble.
  - `S_RUN`: normal fetch; there is no exit except reset.
- Next-PC priority in `S_RUN`, highest first:
  1. `exc_redirect` → `exc_target`. Overrides `stall`.
  2. `stall` → hold PC.
  3. `jump` → `jump_target`.
  4. `branch_taken` → `branch_target`.
  5. Otherwise PC+4.
- Redirect targets have bits [1:0] forced to 00.
- PC+4 uses `adder_32` (a = PC, b = 32'd4) and wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- IF/ID update, same priority:
  - `exc_redirect`, `jump` or `branch_taken` (not stalled) → bubble: instr = `NOP_WORD`, valid = 0, pc and pc4 = 0.
  - `stall` (without `exc_redirect`) → hold all IF/ID fields.
  - Otherwise → load {PC, PC+4, `imem_rdata`}, valid = 1.
- No branch delay slot: the sequential instruction fetched alongside a redirect is discarded.
- `fetch_count` increments by 1 on each edge where IF/ID loads with valid = 1. It wraps 32'hFFFF_FFFF → 0 and holds on stall and bubble.

## Timing
- Reset values: PC = `RESET_PC`, `imem_addr` = `RESET_PC`, `if_id_pc` = 0, `if_id_pc4` = 0, `if_id_instr` = `NOP_WORD`, `if_id_valid` = 0, `fetch_count` = 0, state = `S_BOOT`.
- `imem_addr` is combinational from the PC register, with zero added latency.
- Fetch-to-decode latency is 1 cycle: a word at PC in cycle n appears on `if_id_*` in cycle n+1.
- Redirect penalty is 1 bubble. Redirect asserted in cycle n: the target is fetched in cycle n+1 and reaches IF/ID in cycle n+2; IF/ID holds a bubble in cycle n+1.
- `stall` held k cycles → PC and IF/ID frozen for k cycles, with no lost or duplicated instruction.
- `exc_redirect` together with `stall` → redirect taken and IF/ID flushed.
- `jump` together with `branch_taken` → jump wins.
- Reset asserted mid-operation → all state returns to reset values immediately, with no clock edge required. The first fetch after release occurs one cycle after `S_BOOT`.

## Structure
- Shared package `pipe_defs` holds:
  - `RESET_PC_DEFAULT`, `NOP_WORD`.
  - The `if_state_t` enum (`S_BOOT`, `S_RUN`).
  - The `next_pc_sel_t` encoding (EXC, HOLD, JUMP, BRANCH, SEQ).
- One sub-module: `adder_32` for PC+4.
- Next-PC mux, FSM, IF/ID register and counter are inline.

## Test plan
- Reset, then release and run 4 cycles with `imem_rdata` = 32'h2008_0001: `S_BOOT` bubble first, then `if_id_pc` = 32'h0040_0000, 32'h0040_0004, 32'h0040_0008; `fetch_count` = 3.
- `branch_taken` = 1 with target 32'h0040_0100 at PC 32'h0040_0010: next cycle IF/ID valid = 0 and `imem_addr` = 32'h0040_0100; the following cycle `if_id_pc` = 32'h0040_0100.
- `stall` for 3 cycles at PC 32'h0040_0020: `imem_addr` and all `if_id_*` unchanged for 3 cycles; `fetch_count` is frozen, then resumes at 32'h0040_0024.
- `stall`, `jump` (32'h0040_0200) and `exc_redirect` (32'h0040_0004) all asserted together: PC becomes 32'h0040_0004 and IF/ID is flushed.
- PC preset via jump to 32'hFFFF_FFFC, then run sequentially: next PC = 32'h0000_0000 and `if_id_pc4` = 32'h0000_0000. Separately, `branch_target` 32'h0040_0103 → PC 32'h0040_0100.
- Assert `rst` asynchronously mid-cycle during a stall: outputs return to reset values before the next edge, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset constants,
// FSM state encoding and the next-PC selector encoding.
package pipe_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic {
        S_BOOT,
        S_RUN
    } if_state_t;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_HOLD,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_SEQ
    } next_pc_sel_t;

    // Redirect targets must land on a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_if_stage_adder.sv
// 32-bit wrapping adder used for the PC+4 computation.
module adder_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pipe_if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, boot FSM,
// IF/ID pipeline register and a count of valid fetched instructions.
module pipe_if_stage
    import pipe_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = pipe_defs::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    if_state_t    state_q, state_d;
    next_pc_sel_t sel;
    logic [31:0]  pc_q, pc_d, pc_plus4;
    logic [31:0]  if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  count_q, count_d;

    adder_32 u_pc_adder (
        .a_i   (pc_q),
        .b_i   (32'd4),
        .sum_o (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
            if_instr_q <= NOP_WORD;
            if_valid_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        sel = SEL_SEQ;
        if (exc_redirect)      sel = SEL_EXC;
        else if (stall)        sel = SEL_HOLD;
        else if (jump)         sel = SEL_JUMP;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        count_d    = count_q;
        unique case (state_q)
            S_BOOT: begin
                // One settling cycle: PC stays at the reset vector, IF/ID stays a bubble.
                state_d = S_RUN;
            end
            S_RUN: begin
                unique case (sel)
                    SEL_EXC:    pc_d = word_align(exc_target);
                    SEL_HOLD:   pc_d = pc_q;
                    SEL_JUMP:   pc_d = word_align(jump_target);
                    SEL_BRANCH: pc_d = word_align(branch_target);
                    default:    pc_d = pc_plus4;
                endcase
                if (sel == SEL_SEQ) begin
                    if_pc_d    = pc_q;
                    if_pc4_d   = pc_plus4;
                    if_instr_d = imem_rdata;
                    if_valid_d = 1'b1;
                    count_d    = count_q + 32'd1;
                end else if (sel != SEL_HOLD) begin
                    // No delay slot: the word fetched beside a redirect is squashed.
                    if_pc_d    = 32'd0;
                    if_pc4_d   = 32'd0;
                    if_instr_d = NOP_WORD;
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_pc4   = if_pc4_q;
    assign if_id_instr = if_instr_q;
    assign if_id_valid = if_valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: boot, sequential fetch, branch, stall,
// combined redirects, PC wrap, target alignment and asynchronous reset.
module tb_pipe_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        exc_redirect = 1'b0;
    logic [31:0] exc_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h2008_0001;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr, fetch_count;
    logic        if_id_valid;

    int tests = 0;
    int fails = 0;

    pipe_if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc_redirect  (exc_redirect),
        .exc_target    (exc_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid);
        chk({tag, ".pc"},    if_id_pc,          pc);
        chk({tag, ".pc4"},   if_id_pc4,         pc4);
        chk({tag, ".instr"}, if_id_instr,       instr);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.imem_addr", imem_addr, 32'h0040_0000);
        chk_ifid("rst", 32'd0, 32'd0, 32'd0, 1'b0);
        chk("rst.count", fetch_count, 32'd0);

        // Boot and sequential fetch
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk_ifid("boot", 32'd0, 32'd0, 32'd0, 1'b0);
        chk("boot.imem_addr", imem_addr, 32'h0040_0000);
        step();
        chk_ifid("seq0", 32'h0040_0000, 32'h0040_0004, 32'h2008_0001, 1'b1);
        step();
        chk("seq1.pc", if_id_pc, 32'h0040_0004);
        step();
        chk("seq2.pc", if_id_pc, 32'h0040_0008);
        chk("seq2.count", fetch_count, 32'd3);
        chk("seq2.imem_addr", imem_addr, 32'h0040_000C);
        step();
        chk("seq3.imem_addr", imem_addr, 32'h0040_0010);

        // Branch taken at PC 0x00400010
        branch_taken = 1'b1; branch_target = 32'h0040_0100;
        step();
        branch_taken = 1'b0;
        chk_ifid("br.bubble", 32'd0, 32'd0, 32'd0, 1'b0);
        chk("br.imem_addr", imem_addr, 32'h0040_0100);
        chk("br.count", fetch_count, 32'd4);
        step();
        chk("br.target_pc", if_id_pc, 32'h0040_0100);
        chk("br.count2", fetch_count, 32'd5);

        // Jump to 0x0040001C so the stall lands at PC 0x00400020 with a valid IF/ID
        jump = 1'b1; jump_target = 32'h0040_001C;
        step();
        jump = 1'b0;
        chk("jmp.imem_addr", imem_addr, 32'h0040_001C);
        step();
        chk("prestall.imem_addr", imem_addr, 32'h0040_0020);
        chk("prestall.count", fetch_count, 32'd6);

        // Stall for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.imem_addr", imem_addr, 32'h0040_0020);
            chk_ifid("stall", 32'h0040_001C, 32'h0040_0020, 32'h2008_0001, 1'b1);
            chk("stall.count", fetch_count, 32'd6);
        end
        stall = 1'b0;
        step();
        chk("resume.pc", if_id_pc, 32'h0040_0020);
        chk("resume.imem_addr", imem_addr, 32'h0040_0024);
        chk("resume.count", fetch_count, 32'd7);

        // Exception overrides stall and jump
        stall = 1'b1; jump = 1'b1; jump_target = 32'h0040_0200;
        exc_redirect = 1'b1; exc_target = 32'h0040_0004;
        step();
        stall = 1'b0; jump = 1'b0; exc_redirect = 1'b0;
        chk("exc.imem_addr", imem_addr, 32'h0040_0004);
        chk_ifid("exc.flush", 32'd0, 32'd0, 32'd0, 1'b0);
        chk("exc.count", fetch_count, 32'd7);

        // Jump beats branch; preset PC to the top of the address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        branch_taken = 1'b1; branch_target = 32'h0040_0300;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        chk("jb.imem_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap.imem_addr", imem_addr, 32'h0000_0000);
        chk("wrap.pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", if_id_pc4, 32'h0000_0000);
        chk("wrap.count", fetch_count, 32'd8);

        // Misaligned branch target is forced to a word boundary
        branch_taken = 1'b1; branch_target = 32'h0040_0103;
        step();
        branch_taken = 1'b0;
        chk("align.imem_addr", imem_addr, 32'h0040_0100);
        step();
        chk("align.pc", if_id_pc, 32'h0040_0100);
        chk("align.count", fetch_count, 32'd9);

        // Asynchronous reset mid-cycle during a stall
        stall = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst.imem_addr", imem_addr, 32'h0040_0000);
        chk_ifid("arst", 32'd0, 32'd0, 32'd0, 1'b0);
        chk("arst.count", fetch_count, 32'd0);
        stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("arst.boot_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("arst.first_pc", if_id_pc, 32'h0040_0000);
        chk("arst.first_count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
